// File: rtl/ram8_pkg.sv
// Shared types and defaults for the RAM8 burst master.
// Holds op codes, the FSM state encoding and the width defaults.
package ram8_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 3;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram8_burst_if.sv
// Command, write-stream and read-stream handshakes of the burst master.
// slave: burst master side; master: CPU-side initiator.
interface ram8_burst_if
  import ram8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [AW-1:0]    cmd_len;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_last;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len,
    input  wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid, rd_last
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len,
    output wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid, rd_last
  );

endinterface

// File: rtl/ram8_rd_stage.sv
// Registered read output: data/valid/last plus capture and drain-clear enables.
// Ports: en (in READ), drain (in DRAIN), ready, last_in, din -> cap, clr, data, valid, last.
module ram8_rd_stage
  import ram8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             drain,
  input  logic             ready,
  input  logic             last_in,
  input  logic [WIDTH-1:0] din,
  output logic             cap,
  output logic             clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             last
);

  // Slot is free when empty or being consumed this edge.
  assign cap = en && (!valid || ready);
  assign clr = drain && valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (cap) begin
      data  <= din;
      valid <= 1'b1;
      last  <= last_in;
    end else if (clr) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ram8_burst_master.sv
// Burst initiator for the 8-word RAM: command FSM, address and length counters.
// Ports: clk, rst_n, bus (slave), busy, done, mem_in/mem_address/mem_load/mem_out.
module ram8_burst_master
  import ram8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  ram8_burst_if.slave      bus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mem_in,
  output logic [AW-1:0]    mem_address,
  output logic             mem_load,
  input  logic [WIDTH-1:0] mem_out
);

  state_t        state, state_n;
  logic [AW-1:0] addr;
  logic [AW-1:0] count;
  logic          done_q;
  logic          accept;
  logic          beat;
  logic          cap;
  logic          clr;
  logic          last_cnt;

  assign last_cnt = (count == '0);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    beat    = 1'b0;
    unique case (state)
      IDLE: begin
        accept = bus.cmd_valid;
        if (accept)
          state_n = (bus.cmd_op == OP_READ) ? READ : WRITE;
      end
      WRITE: begin
        beat = bus.wr_valid;
        if (beat && last_cnt) state_n = IDLE;
      end
      READ: begin
        if (cap && last_cnt) state_n = DRAIN;
      end
      DRAIN: begin
        if (clr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (beat && last_cnt) || clr;
      if (accept) begin
        addr  <= bus.cmd_addr;
        count <= bus.cmd_len;
      end else if (beat || cap) begin
        addr <= addr + 1'b1;
        if (!last_cnt) count <= count - 1'b1;
      end
    end
  end

  ram8_rd_stage #(.WIDTH(WIDTH)) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == READ),
    .drain   (state == DRAIN),
    .ready   (bus.rd_ready),
    .last_in (last_cnt),
    .din     (mem_out),
    .cap     (cap),
    .clr     (clr),
    .data    (bus.rd_data),
    .valid   (bus.rd_valid),
    .last    (bus.rd_last)
  );

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign mem_load      = beat;
  assign mem_in        = bus.wr_data;
  assign mem_address   = addr;
  assign busy          = (state != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_ram8_burst_master.sv
// Randomized bench for ram8_burst_master against a word-array memory model.
// Includes a behavioural RAM8 (edge-written, combinational read).
module tb_ram8_burst_master;
  import ram8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, done, mem_load;
  logic [15:0] mem_in, mem_out;
  logic [2:0]  mem_address;
  logic [15:0] ram [8];
  logic [15:0] model [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram8_burst_if bus ();

  ram8_burst_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .mem_in      (mem_in),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(logic op, int a, int l);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = 3'(a);
    bus.cmd_len   = 3'(l);
    #1;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("cmd_accept", 32'(bus.cmd_ready), 1);
    @(posedge clk);
  endtask

  // mode 0: back-to-back, 1: 1,0,1,0.., 2: random gaps
  task automatic write_data(int a, int l, int mode, bit hold);
    int i = 0;
    int c = 0;
    logic [15:0] d;
    while (i <= l && c < 100) begin
      @(negedge clk);
      if (hold) begin
        bus.cmd_op   = OP_READ;
        bus.cmd_addr = 3'd3;
        bus.cmd_len  = 3'd4;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      bus.wr_valid = (mode == 0) ? 1'b1 :
                     (mode == 1) ? (c % 2 == 0) : 1'($urandom % 2);
      d = 16'($urandom);
      bus.wr_data = d;
      #1;
      if (hold) check("no_accept_busy", 32'(bus.cmd_ready), 0);
      check("wr_load", 32'(mem_load), 32'(bus.wr_valid));
      check("wr_ready", 32'(bus.wr_ready), 1);
      check("wr_done_early", 32'(done), 0);
      check("wr_addr", 32'(mem_address), (a + i) % 8);
      if (bus.wr_valid) begin
        check("wr_in", 32'(mem_in), 32'(d));
        model[(a + i) % 8] = d;
        i++;
      end
      c++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    check("wr_beats", i, l + 1);
    check("wr_done", 32'(done), 1);
    check("wr_idle", 32'(busy), 0);
    check("wr_cmd_ready", 32'(bus.cmd_ready), 1);
  endtask

  // mode 0: always ready, 1: 1,0,0,1,0,0.., 2: random
  task automatic read_data(int a, int l, int mode);
    int   k = 0;
    int   c = 0;
    logic held = 1'b0;
    logic [15:0] hd = '0;
    while (k <= l && c < 200) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rd_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? (c % 3 == 0) : 1'($urandom % 2);
      #1;
      check("rd_noload", 32'(mem_load), 0);
      if (held) begin
        check("rd_hold_v", 32'(bus.rd_valid), 1);
        check("rd_hold_d", 32'(bus.rd_data), 32'(hd));
      end
      held = bus.rd_valid && !bus.rd_ready;
      hd   = bus.rd_data;
      if (bus.rd_valid && bus.rd_ready) begin
        check("rd_data", 32'(bus.rd_data), 32'(model[(a + k) % 8]));
        check("rd_last", 32'(bus.rd_last), 32'(k == l));
        k++;
      end
      c++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.rd_ready = 1'b0;
    #1;
    check("rd_beats", k, l + 1);
    check("rd_done", 32'(done), 1);
    check("rd_valid_clr", 32'(bus.rd_valid), 0);
    check("rd_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [15:0] d;
    int a, l, m;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_load", 32'(mem_load), 0);
    check("rst_addr", 32'(mem_address), 0);
    rst_n = 1'b1;

    send_cmd(OP_WRITE, 0, 7);
    write_data(0, 7, 2, 1'b0);

    send_cmd(OP_WRITE, 2, 2);
    write_data(2, 2, 0, 1'b0);

    send_cmd(OP_WRITE, 6, 3);
    write_data(6, 3, 0, 1'b0);
    send_cmd(OP_READ, 6, 3);
    read_data(6, 3, 0);

    a = int'($urandom % 8);
    send_cmd(OP_READ, a, 7);
    read_data(a, 7, 1);

    send_cmd(OP_WRITE, 4, 1);
    write_data(4, 1, 0, 1'b1);
    @(posedge clk);
    read_data(3, 4, 0);

    send_cmd(OP_WRITE, 1, 2);
    write_data(1, 2, 1, 1'b0);

    send_cmd(OP_WRITE, 5, 7);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    d = 16'($urandom);
    bus.wr_data = d;
    @(posedge clk);
    model[5] = d;
    @(negedge clk);
    bus.wr_data = 16'($urandom);
    #1;
    check("pre_rst_load", 32'(mem_load), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_load", 32'(mem_load), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 1);

    send_cmd(OP_READ, 4, 3);
    read_data(4, 3, 0);

    for (int it = 0; it < 24; it++) begin
      a = int'($urandom % 8);
      l = int'($urandom % 8);
      m = int'($urandom % 3);
      if ($urandom % 2 == 0) begin
        send_cmd(OP_WRITE, a, l);
        write_data(a, l, m, 1'b0);
      end else begin
        send_cmd(OP_READ, a, l);
        read_data(a, l, m);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
